// File: rtl/cpu_pkg.sv
// Shared constants and types for the CPU control unit: instruction field layout,
// opcode and ALU-op encodings, sequencer states and the opcode decode payload.
package cpu_pkg;

    // Instruction word layout: {OP[31:24], RD[23:16], RT[15:8], RS/IMM[7:0]}
    localparam int unsigned FIELD_W = 8;
    localparam int unsigned OP_POS  = 24;
    localparam int unsigned RD_POS  = 16;
    localparam int unsigned RT_POS  = 8;
    localparam int unsigned RS_POS  = 0;

    localparam int unsigned ALUOP_W = 3;

    localparam logic [FIELD_W-1:0] OP_LOADI = 8'd0;
    localparam logic [FIELD_W-1:0] OP_MOV   = 8'd1;
    localparam logic [FIELD_W-1:0] OP_ADD   = 8'd2;
    localparam logic [FIELD_W-1:0] OP_SUB   = 8'd3;
    localparam logic [FIELD_W-1:0] OP_AND   = 8'd4;
    localparam logic [FIELD_W-1:0] OP_OR    = 8'd5;

    localparam logic [ALUOP_W-1:0] ALU_FWD = 3'b000;
    localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    typedef struct packed {
        logic [ALUOP_W-1:0] aluop;
        logic               imm_sel;
        logic               neg_sel;
        logic               wr_valid;
        logic               illegal;
    } dec_t;

endpackage

// File: rtl/ctrl_opcode_decode.sv
// Combinational opcode decoder: maps the instruction opcode to ALU op, operand
// muxing, register-file write qualification and the illegal-opcode flag.
module ctrl_opcode_decode
    import cpu_pkg::*;
(
    input  logic [FIELD_W-1:0] i_op,
    output dec_t               o_dec_c
);

    always_comb begin
        o_dec_c.aluop    = ALU_FWD;
        o_dec_c.imm_sel  = 1'b0;
        o_dec_c.neg_sel  = 1'b0;
        o_dec_c.wr_valid = 1'b1;
        o_dec_c.illegal  = 1'b0;
        case (i_op)
            OP_LOADI: o_dec_c.imm_sel = 1'b1;
            OP_MOV:   o_dec_c.aluop   = ALU_FWD;
            OP_ADD:   o_dec_c.aluop   = ALU_ADD;
            // SUB is an ADD with operand2 two's-complemented
            OP_SUB: begin
                o_dec_c.aluop   = ALU_ADD;
                o_dec_c.neg_sel = 1'b1;
            end
            OP_AND:   o_dec_c.aluop   = ALU_AND;
            OP_OR:    o_dec_c.aluop   = ALU_OR;
            default: begin
                o_dec_c.wr_valid = 1'b0;
                o_dec_c.illegal  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Instruction decode/sequencing stage (IDLE/DECODE/EXEC/WB/HALT) in front of the
// register file and ALU. Optional feature macro: CTRL_ILLEGAL_TRAP_EN (illegal-opcode trap/halt).
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned INSTR_W    = 32,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned REG_ADDR_W = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [INSTR_W-1:0]    i_instr,
    input  logic                  i_instr_valid,
    output logic                  o_instr_ready,
    output logic [REG_ADDR_W-1:0] o_readreg1,
    output logic [REG_ADDR_W-1:0] o_readreg2,
    output logic [REG_ADDR_W-1:0] o_writereg,
    output logic                  o_writeenable,
    output logic [DATA_W-1:0]     o_immediate,
    output logic [ALUOP_W-1:0]    o_aluop,
    output logic                  o_imm_sel,
    output logic                  o_neg_sel,
    output logic [CNT_W-1:0]      o_retired_cnt,
    output logic                  o_trap
);

    state_t              r_state;
    state_t              w_state_next;
    logic [INSTR_W-1:0]  r_ir;
    logic [CNT_W-1:0]    r_retired_cnt;
    dec_t                w_dec;
    logic                w_accept;
    logic                w_unused;

    ctrl_opcode_decode u_opcode_decode (
        .i_op    (r_ir[OP_POS +: FIELD_W]),
        .o_dec_c (w_dec)
    );

    assign w_accept = i_instr_valid && o_instr_ready;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_instr_valid) begin
                    w_state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_state_next = ST_EXEC;
`ifdef CTRL_ILLEGAL_TRAP_EN
                if (w_dec.illegal) begin
                    w_state_next = ST_HALT;
                end
`endif
            end
            ST_EXEC: w_state_next = ST_WB;
            ST_WB: begin
                if (i_instr_valid) begin
                    w_state_next = ST_DECODE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_HALT: w_state_next = ST_HALT;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output logic: control strokes decoded from state and the held IR
    always_comb begin
        o_instr_ready = 1'b0;
        o_writeenable = 1'b0;
        o_aluop       = ALU_FWD;
        o_imm_sel     = 1'b0;
        o_neg_sel     = 1'b0;
        case (r_state)
            ST_IDLE: o_instr_ready = 1'b1;
            ST_DECODE, ST_EXEC: begin
                o_aluop   = w_dec.aluop;
                o_imm_sel = w_dec.imm_sel;
                o_neg_sel = w_dec.neg_sel;
            end
            ST_WB: begin
                o_instr_ready = 1'b1;
                o_writeenable = w_dec.wr_valid;
                o_aluop       = w_dec.aluop;
                o_imm_sel     = w_dec.imm_sel;
                o_neg_sel     = w_dec.neg_sel;
            end
            default: ;
        endcase
    end

    // Instruction register and retired-instruction counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ir          <= '0;
            r_retired_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_ir <= i_instr;
            end
            if (r_state == ST_WB) begin
                r_retired_cnt <= r_retired_cnt + CNT_W'(1);
            end
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic r_trap;

    // Sticky trap, cleared only by reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_trap <= 1'b0;
        end else if ((r_state == ST_DECODE) && w_dec.illegal) begin
            r_trap <= 1'b1;
        end
    end

    assign o_trap = r_trap;
`else
    assign o_trap = 1'b0;
`endif

    assign o_readreg1    = r_ir[RT_POS +: REG_ADDR_W];
    assign o_readreg2    = r_ir[RS_POS +: REG_ADDR_W];
    assign o_writereg    = r_ir[RD_POS +: REG_ADDR_W];
    assign o_immediate   = r_ir[RS_POS +: DATA_W];
    assign o_retired_cnt = r_retired_cnt;

    // Upper register-field bits are deliberately ignored
    assign w_unused = ^{r_ir[RD_POS + REG_ADDR_W +: FIELD_W - REG_ADDR_W],
                        r_ir[RT_POS + REG_ADDR_W +: FIELD_W - REG_ADDR_W],
                        w_dec.illegal};

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: directed scenarios plus randomized
// instruction streams checked against a behavioural decode/sequence model.
module tb_cpu_control_unit;

    localparam int unsigned TB_CNT_W = 4;
    localparam int          CNT_MOD  = 1 << TB_CNT_W;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [31:0]         i_instr;
    logic                i_instr_valid;
    logic                o_instr_ready;
    logic [2:0]          o_readreg1;
    logic [2:0]          o_readreg2;
    logic [2:0]          o_writereg;
    logic                o_writeenable;
    logic [7:0]          o_immediate;
    logic [2:0]          o_aluop;
    logic                o_imm_sel;
    logic                o_neg_sel;
    logic [TB_CNT_W-1:0] o_retired_cnt;
    logic                o_trap;

    int vectors     = 0;
    int miscompares = 0;
    int exp_cnt     = 0;

    always #5 clk = ~clk;

    cpu_control_unit #(
        .INSTR_W    (32),
        .DATA_W     (8),
        .REG_ADDR_W (3),
        .CNT_W      (TB_CNT_W)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_instr       (i_instr),
        .i_instr_valid (i_instr_valid),
        .o_instr_ready (o_instr_ready),
        .o_readreg1    (o_readreg1),
        .o_readreg2    (o_readreg2),
        .o_writereg    (o_writereg),
        .o_writeenable (o_writeenable),
        .o_immediate   (o_immediate),
        .o_aluop       (o_aluop),
        .o_imm_sel     (o_imm_sel),
        .o_neg_sel     (o_neg_sel),
        .o_retired_cnt (o_retired_cnt),
        .o_trap        (o_trap)
    );

    typedef struct packed {
        logic [2:0] aluop;
        logic       imm;
        logic       neg;
        logic       wr;
        logic       illegal;
    } exp_t;

    // Opcode table: 0 LOADI, 1 MOV, 2 ADD, 3 SUB, 4 AND, 5 OR, anything else illegal
    function automatic exp_t ref_decode(input logic [7:0] op);
        exp_t e;
        e = '0;
        if (op > 8'd5) begin
            e.illegal = 1'b1;
        end else begin
            e.wr    = 1'b1;
            e.imm   = (op == 8'd0);
            e.neg   = (op == 8'd3);
            e.aluop = (op == 8'd2 || op == 8'd3) ? 3'b001 :
                      (op == 8'd4) ? 3'b010 :
                      (op == 8'd5) ? 3'b011 : 3'b000;
        end
        return e;
    endfunction

    // Layout: rr1[23:21] rr2[20:18] wr[17:15] imm[14:7] aluop[6:4] imm_sel[3] neg[2] we[1] rdy[0]
    function automatic logic [23:0] snap();
        return {o_readreg1, o_readreg2, o_writereg, o_immediate, o_aluop,
                o_imm_sel, o_neg_sel, o_writeenable, o_instr_ready};
    endfunction

    function automatic logic [23:0] expect_snap(input logic [31:0] ins, input exp_t e,
                                                input logic we, input logic rdy);
        return {ins[10:8], ins[2:0], ins[18:16], ins[7:0], e.aluop, e.imm, e.neg, we, rdy};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [7:0] op;
        op = 8'($urandom_range(0, 5));
`ifndef CTRL_ILLEGAL_TRAP_EN
        if ($urandom_range(0, 5) == 0) op = 8'($urandom_range(6, 255));
`endif
        return {op, 8'($urandom), 8'($urandom), 8'($urandom)};
    endfunction

    task automatic apply_reset();
        rst_n         = 1'b0;
        i_instr_valid = 1'b0;
        i_instr       = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge where the instruction sits in DECODE
    task automatic issue(input logic [31:0] ins, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (o_instr_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        i_instr       = ins;
        i_instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (snap() !== 24'h000001) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want %h", snap(), 24'h000001);
        end
        vectors++;
        if ({o_retired_cnt, o_trap} !== {TB_CNT_W'(0), 1'b0}) begin
            miscompares++;
            $display("FAIL reset_cnt_trap: got cnt=%0d trap=%b want cnt=0 trap=0", o_retired_cnt, o_trap);
        end
    endtask

    task automatic test_loadi();
        logic [31:0] ins = 32'h0002_002A;
        logic [3:0]  we_hist;
        exp_t        e;
        bit          ok;
        e = ref_decode(ins[31:24]);
        issue(ins, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL loadi_ready: got timeout want ready"); end
        vectors++;
        if ({o_writereg, o_immediate, o_imm_sel, o_aluop} !== {3'd2, 8'h2A, 1'b1, 3'b000}) begin
            miscompares++;
            $display("FAIL loadi_decode: got wr=%0d imm=%h isel=%b op=%b want wr=2 imm=2a isel=1 op=000",
                     o_writereg, o_immediate, o_imm_sel, o_aluop);
        end
        we_hist[0] = o_writeenable;
        @(negedge clk);
        we_hist[1] = o_writeenable;
        @(negedge clk);
        we_hist[2] = o_writeenable;
        vectors++;
        if (snap() !== expect_snap(ins, e, 1'b1, 1'b1)) begin
            miscompares++;
            $display("FAIL loadi_wb: got %h want %h", snap(), expect_snap(ins, e, 1'b1, 1'b1));
        end
        @(posedge clk);
        exp_cnt = (exp_cnt + 1) % CNT_MOD;
        @(negedge clk);
        we_hist[3] = o_writeenable;
        vectors++;
        if (we_hist !== 4'b0100) begin
            miscompares++;
            $display("FAIL loadi_we_timing: got %b want 0100", we_hist);
        end
        vectors++;
        if (o_retired_cnt !== TB_CNT_W'(exp_cnt)) begin
            miscompares++;
            $display("FAIL loadi_cnt: got %0d want %0d", o_retired_cnt, exp_cnt);
        end
    endtask

    task automatic test_sub();
        logic [31:0] ins = 32'h0303_0100;
        logic [3:0]  we_hist;
        bit          ok;
        issue(ins, ok);
        vectors++;
        if ({ok, o_readreg1, o_readreg2, o_writereg, o_aluop, o_neg_sel, o_imm_sel} !==
            {1'b1, 3'd1, 3'd0, 3'd3, 3'b001, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL sub_decode: got ok=%b r1=%0d r2=%0d wr=%0d op=%b neg=%b isel=%b",
                     ok, o_readreg1, o_readreg2, o_writereg, o_aluop, o_neg_sel, o_imm_sel);
        end
        we_hist[0] = o_writeenable;
        @(negedge clk);
        we_hist[1] = o_writeenable;
        @(negedge clk);
        we_hist[2] = o_writeenable;
        @(posedge clk);
        exp_cnt = (exp_cnt + 1) % CNT_MOD;
        @(negedge clk);
        we_hist[3] = o_writeenable;
        vectors++;
        if (we_hist !== 4'b0100) begin
            miscompares++;
            $display("FAIL sub_single_we: got %b want 0100", we_hist);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] add_i = 32'h0205_0304;
        logic [31:0] or_i  = 32'h0506_0102;
        int          hs_q[$];
        apply_reset();
        i_instr       = add_i;
        i_instr_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (o_instr_ready && i_instr_valid) hs_q.push_back(c);
            @(posedge clk);
            @(negedge clk);
            if (hs_q.size() == 1) i_instr = or_i;
            if (hs_q.size() == 2) begin
                i_instr_valid = 1'b0;
                break;
            end
        end
        vectors++;
        if (hs_q.size() != 2 || (hs_q[1] - hs_q[0]) != 3) begin
            miscompares++;
            $display("FAIL b2b_spacing: got %0d handshakes (gap %0d) want 2 (gap 3)",
                     hs_q.size(), (hs_q.size() == 2) ? hs_q[1] - hs_q[0] : -1);
        end
        vectors++;
        if (snap() !== expect_snap(or_i, ref_decode(or_i[31:24]), 1'b0, 1'b0)) begin
            miscompares++;
            $display("FAIL b2b_second_decode: got %h want %h", snap(),
                     expect_snap(or_i, ref_decode(or_i[31:24]), 1'b0, 1'b0));
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        exp_cnt = 2;
        vectors++;
        if (o_retired_cnt !== TB_CNT_W'(2)) begin
            miscompares++;
            $display("FAIL b2b_cnt: got %0d want 2", o_retired_cnt);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] ins = 32'h0701_0203;
        logic        any_we = 1'b0;
        logic        any_rdy = 1'b0;
        int          cnt_before;
        bit          ok;
        cnt_before = exp_cnt;
        issue(ins, ok);
`ifdef CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 6; i++) begin
            any_we  = any_we | o_writeenable;
            any_rdy = any_rdy | o_instr_ready;
            @(negedge clk);
        end
        vectors++;
        if ({ok, o_trap, any_rdy, any_we} !== 4'b1100) begin
            miscompares++;
            $display("FAIL illegal_halt: got ok=%b trap=%b rdy=%b we=%b want 1 1 0 0", ok, o_trap, any_rdy, any_we);
        end
        vectors++;
        if (o_retired_cnt !== TB_CNT_W'(cnt_before)) begin
            miscompares++;
            $display("FAIL illegal_cnt: got %0d want %0d", o_retired_cnt, cnt_before);
        end
        apply_reset();
        vectors++;
        if ({o_trap, o_instr_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL illegal_reset_clear: got trap=%b rdy=%b want 0 1", o_trap, o_instr_ready);
        end
`else
        for (int i = 0; i < 3; i++) begin
            any_we = any_we | o_writeenable;
            if (i < 2) @(negedge clk);
        end
        any_rdy = o_instr_ready;
        @(posedge clk);
        exp_cnt = (exp_cnt + 1) % CNT_MOD;
        @(negedge clk);
        vectors++;
        if ({ok, o_trap, any_rdy, any_we} !== 4'b1010) begin
            miscompares++;
            $display("FAIL illegal_nop: got ok=%b trap=%b wb_rdy=%b we=%b want 1 0 1 0", ok, o_trap, any_rdy, any_we);
        end
        vectors++;
        if (o_retired_cnt !== TB_CNT_W'((cnt_before + 1) % CNT_MOD)) begin
            miscompares++;
            $display("FAIL illegal_cnt: got %0d want %0d", o_retired_cnt, (cnt_before + 1) % CNT_MOD);
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] cur;
        logic [31:0] nxt;
        logic [23:0] msk;
        exp_t        e;
        bit          ok;
        bit          early;
        bit          b2b;
        cur = rand_instr();
        issue(cur, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL rand_first_ready: got timeout want ready"); end
        for (int k = 0; k < 40; k++) begin
            e     = ref_decode(cur[31:24]);
            msk   = e.illegal ? 24'hFFFF83 : 24'hFFFFFF;
            nxt   = rand_instr();
            early = ($urandom_range(0, 1) == 1);
            b2b   = early || ($urandom_range(0, 1) == 1);
            vectors++;
            if ((snap() & msk) !== (expect_snap(cur, e, 1'b0, 1'b0) & msk)) begin
                miscompares++;
                $display("FAIL rand_decode: instr=%h got %h want %h", cur, snap(), expect_snap(cur, e, 1'b0, 1'b0));
            end
            @(negedge clk);
            vectors++;
            if ((snap() & msk) !== (expect_snap(cur, e, 1'b0, 1'b0) & msk)) begin
                miscompares++;
                $display("FAIL rand_exec: instr=%h got %h want %h", cur, snap(), expect_snap(cur, e, 1'b0, 1'b0));
            end
            if (early) begin
                i_instr       = nxt;
                i_instr_valid = 1'b1;
            end
            @(negedge clk);
            vectors++;
            if ((snap() & msk) !== (expect_snap(cur, e, e.wr, 1'b1) & msk)) begin
                miscompares++;
                $display("FAIL rand_wb: instr=%h got %h want %h", cur, snap(), expect_snap(cur, e, e.wr, 1'b1));
            end
            vectors++;
            if (o_retired_cnt !== TB_CNT_W'(exp_cnt)) begin
                miscompares++;
                $display("FAIL rand_cnt_wb: got %0d want %0d", o_retired_cnt, exp_cnt);
            end
            if (b2b) begin
                i_instr       = nxt;
                i_instr_valid = 1'b1;
            end
            @(posedge clk);
            exp_cnt = (exp_cnt + 1) % CNT_MOD;
            @(negedge clk);
            i_instr_valid = 1'b0;
            if (!b2b) begin
                vectors++;
                if ({o_aluop, o_imm_sel, o_neg_sel, o_writeenable, o_instr_ready, o_retired_cnt} !==
                    {7'b0000001, TB_CNT_W'(exp_cnt)}) begin
                    miscompares++;
                    $display("FAIL rand_idle: got op=%b isel=%b neg=%b we=%b rdy=%b cnt=%0d want 0 0 0 0 1 %0d",
                             o_aluop, o_imm_sel, o_neg_sel, o_writeenable, o_instr_ready, o_retired_cnt, exp_cnt);
                end
                repeat ($urandom_range(0, 2)) @(negedge clk);
                issue(nxt, ok);
                vectors++;
                if (!ok) begin miscompares++; $display("FAIL rand_ready: got timeout want ready"); end
            end
            cur = nxt;
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        exp_cnt = (exp_cnt + 1) % CNT_MOD;
        @(negedge clk);
        vectors++;
        if (o_retired_cnt !== TB_CNT_W'(exp_cnt)) begin
            miscompares++;
            $display("FAIL rand_drain_cnt: got %0d want %0d", o_retired_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] ins = 32'h0004_0055;
        bit          ok;
        issue(ins, ok);
        repeat (2) @(negedge clk);
        vectors++;
        if ({ok, o_writeenable} !== 2'b11) begin
            miscompares++;
            $display("FAIL resetmid_in_wb: got ok=%b we=%b want 1 1", ok, o_writeenable);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({o_writeenable, o_instr_ready, o_aluop, o_imm_sel, o_neg_sel, o_immediate, o_trap, o_retired_cnt} !==
            {2'b01, 3'b000, 2'b00, 8'h00, 1'b0, TB_CNT_W'(0)}) begin
            miscompares++;
            $display("FAIL resetmid_async: got we=%b rdy=%b op=%b imm=%h cnt=%0d want 0 1 000 00 0",
                     o_writeenable, o_instr_ready, o_aluop, o_immediate, o_retired_cnt);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
        vectors++;
        if ({o_writeenable, o_instr_ready, o_retired_cnt} !== {2'b01, TB_CNT_W'(0)}) begin
            miscompares++;
            $display("FAIL resetmid_release: got we=%b rdy=%b cnt=%0d want 0 1 0",
                     o_writeenable, o_instr_ready, o_retired_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] ins;
        bit          ok;
        apply_reset();
        for (int n = 1; n <= 17; n++) begin
            ins = {8'($urandom_range(0, 5)), 8'($urandom), 8'($urandom), 8'($urandom)};
            issue(ins, ok);
            repeat (2) @(negedge clk);
            @(posedge clk);
            exp_cnt = (exp_cnt + 1) % CNT_MOD;
            @(negedge clk);
            if (n == 16 || n == 17) begin
                vectors++;
                if ({ok, o_retired_cnt} !== {1'b1, TB_CNT_W'(exp_cnt)}) begin
                    miscompares++;
                    $display("FAIL wrap_cnt_%0d: got ok=%b cnt=%0d want ok=1 cnt=%0d", n, ok, o_retired_cnt, exp_cnt);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        i_instr       = '0;
        i_instr_valid = 1'b0;
        test_reset();
        test_loadi();
        test_sub();
        test_back_to_back();
`ifndef CTRL_ILLEGAL_TRAP_EN
        test_illegal();
`endif
        test_random();
        test_reset_mid();
        test_wrap();
`ifdef CTRL_ILLEGAL_TRAP_EN
        test_illegal();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
